// File: rtl/fifo_sync_flags_if.sv
// Handshake bundle for fifo_sync_flags.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface fifo_sync_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
);
  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PTR_WIDTH:0]    fill_level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, r_en, data_in,
    input  data_out, full, empty, almost_full, almost_empty, fill_level, overflow, underflow
  );

  modport slave (
    input  w_en, r_en, data_in,
    output data_out, full, empty, almost_full, almost_empty, fill_level, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with level count, almost-full/almost-empty thresholds and overflow/underflow pulses.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered on each accepted read.
module fifo_sync_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter int PTR_WIDTH     = 3,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic            clk,
  input  logic            rst,
  fifo_sync_flags_if.slave bus
);
  localparam logic [PTR_WIDTH:0] PTR_ONE    = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0] AFULL_LVL  = (PTR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [PTR_WIDTH:0] AEMPTY_LVL = (PTR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_WIDTH:0]    wptr_r;
  logic [PTR_WIDTH:0]    rptr_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic [PTR_WIDTH:0]    level_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  wa_s;
  logic                  ra_s;

  // Flag decode and acceptance; both are judged on the pre-edge pointers only.
  always_comb begin
    level_s = wptr_r - rptr_r;
    full_s  = (wptr_r[PTR_WIDTH] != rptr_r[PTR_WIDTH]) &&
              (wptr_r[PTR_WIDTH-1:0] == rptr_r[PTR_WIDTH-1:0]);
    empty_s = (wptr_r == rptr_r);
    wa_s    = bus.w_en && !full_s;
    ra_s    = bus.r_en && !empty_s;
  end

  // Pointer and error-pulse registers; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wa_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (ra_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      overflow_r  <= bus.w_en && full_s;
      underflow_r <= bus.r_en && empty_s;
    end
  end

  // Storage array; contents are never cleared since reset discards them via the pointers.
  always_ff @(posedge clk) begin
    if (wa_s && !rst) begin
      mem_r[wptr_r[PTR_WIDTH-1:0]] <= bus.data_in;
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head word is presented directly; meaningless while empty.
  assign bus.data_out = mem_r[rptr_r[PTR_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] dout_r;

  // Read data register; holds its value on idle cycles and rejected reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= '0;
    end else if (ra_s) begin
      dout_r <= mem_r[rptr_r[PTR_WIDTH-1:0]];
    end
  end

  assign bus.data_out = dout_r;
`endif

  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.fill_level   = level_s;
  assign bus.almost_full  = (level_s >= AFULL_LVL);
  assign bus.almost_empty = (level_s <= AEMPTY_LVL);
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule
